// File: rtl/scoreboard_regfile.sv
// Per-thread register file with scoreboard bits and post-reset clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle writes/allocs to reads.
module scoreboard_regfile #(
  parameter int LOG_REG_CNT           = 2,
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int REG_WIDTH             = 288,
  parameter int NUM_RD                = 2,
  parameter int NUM_WR                = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic freeze,
  output logic ready,
  input  logic [NUM_RD*(LOG_REG_CNT+LOG_SUPERSCALAR_WIDTH)-1:0] rd_addr,
  output logic [NUM_RD*REG_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0] rd_pending,
  input  logic [NUM_WR-1:0] wr_en,
  input  logic [NUM_WR*(LOG_REG_CNT+LOG_SUPERSCALAR_WIDTH)-1:0] wr_addr,
  input  logic [NUM_WR*REG_WIDTH-1:0] wr_data,
  input  logic alloc_en,
  input  logic [LOG_REG_CNT+LOG_SUPERSCALAR_WIDTH-1:0] alloc_addr,
  output logic wr_conflict
);

  localparam int AW    = LOG_REG_CNT + LOG_SUPERSCALAR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam int RW    = REG_WIDTH;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state;
  logic [AW:0]     ptr;
  logic [RW-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] pending;
  logic            conflict;
  logic [RW-1:0]   rd_nxt [NUM_RD];
  logic [NUM_RD-1:0] pd_nxt;

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
          conflict = 1'b1;
      end
    end
  end

  // Later ports override earlier ones, so the highest index wins.
  always_comb begin
    pd_nxt = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_nxt[r] = mem[rd_addr[r*AW +: AW]];
      pd_nxt[r] = pending[rd_addr[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] &&
            wr_addr[w*AW +: AW] == rd_addr[r*AW +: AW]) begin
          rd_nxt[r] = wr_data[w*RW +: RW];
          pd_nxt[r] = 1'b0;
        end
      end
      if (alloc_en && alloc_addr == rd_addr[r*AW +: AW])
        pd_nxt[r] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[ptr[AW-1:0]] <= '0;
    end else if (!freeze) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w])
          mem[wr_addr[w*AW +: AW]] <= wr_data[w*RW +: RW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_CLEAR;
      ptr         <= '0;
      ready       <= 1'b0;
      rd_data     <= '0;
      rd_pending  <= '0;
      wr_conflict <= 1'b0;
      pending     <= '0;
    end else if (state == S_CLEAR) begin
      pending[ptr[AW-1:0]] <= 1'b0;
      ptr <= ptr + (AW+1)'(1);
      if (ptr == (AW+1)'(DEPTH - 1)) begin
        state <= S_RUN;
        ready <= 1'b1;
      end
    end else if (!freeze) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w])
          pending[wr_addr[w*AW +: AW]] <= 1'b0;
      end
      // Alloc after writes: a new producer outranks a retiring one.
      if (alloc_en)
        pending[alloc_addr] <= 1'b1;
      for (int r = 0; r < NUM_RD; r++)
        rd_data[r*RW +: RW] <= rd_nxt[r];
      rd_pending  <= pd_nxt;
      wr_conflict <= conflict;
    end else begin
      wr_conflict <= 1'b0;
    end
  end

endmodule
